// File: rtl/philv_mem_pkg.sv
// -----------------------------------------------------------------------------
// philv_mem_pkg
// Shared types and constants for the philosophyVCore unified-memory arbiter.
//   state_t     : arbiter FSM states (IDLE, WAIT)
//   REQ_IF/LS   : owner encoding of the access in flight
//   DEF_ADDR_W  : default address width
//   DEF_DATA_W  : default data width
// -----------------------------------------------------------------------------
package philv_mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

endpackage

// File: rtl/philv_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// philv_mem_arbiter_if
// Bundles the fetch requester, load/store requester and memory command/response
// signals of the unified-memory arbiter.
//   if_*   : IF-stage fetch request / grant / response
//   ls_*   : MEM-stage load/store request / grant / response
//   mem_*  : single-port memory command and read data
// Modports:
//   slave  : the arbiter (consumes requests and read data, drives the rest)
//   master : requesters plus memory (drive requests and read data)
// -----------------------------------------------------------------------------
interface philv_mem_arbiter_if
  import philv_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  ls_req;
  logic                  ls_we;
  logic [ADDR_W-1:0]     ls_addr;
  logic [DATA_W-1:0]     ls_wdata;
  logic [DATA_W/8-1:0]   ls_be;
  logic                  ls_gnt;
  logic                  ls_rvalid;
  logic [DATA_W-1:0]     ls_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [DATA_W/8-1:0]   mem_be;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/philv_starve_ctr.sv
// -----------------------------------------------------------------------------
// philv_starve_ctr
// Saturating count of consecutive load/store grants taken while a fetch was
// waiting. Once it reaches LIMIT the arbiter hands the next slot to fetch.
//   i_clk   : core clock
//   i_rstb  : synchronous active-low reset
//   i_clear : fetch was granted or is not requesting
//   i_incr  : load/store granted while fetch was requesting
//   o_limit : count has reached LIMIT
// -----------------------------------------------------------------------------
module philv_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_rstb,
  input  logic i_clear,
  input  logic i_incr,
  output logic o_limit
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIMIT_VAL = W'(LIMIT);

  logic [W-1:0] r_count;

  // Clear wins over increment so a fetch grant in the same cycle always
  // restarts the window; the count parks at LIMIT until fetch gets served.
  always_ff @(posedge i_clk) begin
    if (!i_rstb) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_incr && (r_count != LIMIT_VAL)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_limit = (r_count == LIMIT_VAL);

endmodule

// File: rtl/philv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// philv_mem_arbiter
// Shares one single-port memory between instruction fetch (IF) and load/store
// (LS). One access is in flight at a time; its response comes back exactly
// MEM_LATENCY cycles after the grant and the next access may issue in that
// same response cycle. LS wins by default; after STARVE_LIMIT back-to-back LS
// grants with a fetch waiting, fetch takes the next slot.
//   i_clk   : core clock
//   i_rstb  : synchronous active-low reset; all outputs forced low while low
//   bus     : requester and memory signals (philv_mem_arbiter_if.slave)
//   o_busy  : an access is outstanding
// -----------------------------------------------------------------------------
module philv_mem_arbiter
  import philv_mem_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                i_clk,
  input  logic                i_rstb,
  philv_mem_arbiter_if.slave  bus,
  output logic                o_busy
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             r_state;
  state_t             w_nextState;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_nextCnt;
  logic               r_owner;
  logic               w_nextOwner;
  logic               r_we;
  logic               w_nextWe;

  logic               w_respCycle;
  logic               w_issueSlot;
  logic               w_issue;
  logic               w_pickIf;
  logic               w_starveLimit;
  logic               w_starveClr;
  logic               w_starveInc;

  philv_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .i_clk   (i_clk),
    .i_rstb  (i_rstb),
    .i_clear (w_starveClr),
    .i_incr  (w_starveInc),
    .o_limit (w_starveLimit)
  );

  // State register: FSM state, latency countdown and the owner/direction of
  // the access in flight. Reset drops any outstanding access.
  always_ff @(posedge i_clk) begin
    if (!i_rstb) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_owner <= REQ_IF;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_owner <= w_nextOwner;
      r_we    <= w_nextWe;
    end
  end

  // Next-state and outputs. Everything is gated by i_rstb so grants and the
  // memory strobe stay low during reset even though they are combinational.
  // The response cycle doubles as an issue slot, giving one access per
  // MEM_LATENCY cycles.
  always_comb begin
    w_nextState   = r_state;
    w_nextCnt     = r_cnt;
    w_nextOwner   = r_owner;
    w_nextWe      = r_we;
    w_pickIf      = 1'b0;
    w_issue       = 1'b0;
    w_starveClr   = 1'b0;
    w_starveInc   = 1'b0;
    o_busy        = 1'b0;
    bus.if_gnt    = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.if_rdata  = {DATA_W{1'b0}};
    bus.ls_gnt    = 1'b0;
    bus.ls_rvalid = 1'b0;
    bus.ls_rdata  = {DATA_W{1'b0}};
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = {(DATA_W/8){1'b0}};
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};

    w_respCycle = (r_state == WAIT) && (r_cnt == CNT_ONE);
    w_issueSlot = (r_state == IDLE) || w_respCycle;

    if (i_rstb) begin
      o_busy = (r_state == WAIT);

      if (w_respCycle) begin
        if (r_owner == REQ_LS) begin
          bus.ls_rvalid = 1'b1;
          bus.ls_rdata  = r_we ? {DATA_W{1'b0}} : bus.mem_rdata;
        end else begin
          bus.if_rvalid = 1'b1;
          bus.if_rdata  = bus.mem_rdata;
        end
      end

      w_pickIf = bus.if_req && (w_starveLimit || !bus.ls_req);
      w_issue  = w_issueSlot && (bus.if_req || bus.ls_req);

      if (w_issue) begin
        bus.mem_en  = 1'b1;
        w_nextState = WAIT;
        w_nextCnt   = CNT_LOAD;
        if (w_pickIf) begin
          bus.if_gnt    = 1'b1;
          bus.mem_addr  = bus.if_addr;
          bus.mem_be    = {(DATA_W/8){1'b1}};
          w_nextOwner   = REQ_IF;
          w_nextWe      = 1'b0;
        end else begin
          bus.ls_gnt    = 1'b1;
          bus.mem_we    = bus.ls_we;
          bus.mem_addr  = bus.ls_addr;
          bus.mem_wdata = bus.ls_wdata;
          bus.mem_be    = bus.ls_we ? bus.ls_be : {(DATA_W/8){1'b1}};
          w_nextOwner   = REQ_LS;
          w_nextWe      = bus.ls_we;
        end
      end else if (r_state == WAIT) begin
        w_nextCnt = r_cnt - CNT_ONE;
        if (w_respCycle) begin
          w_nextState = IDLE;
        end
      end

      w_starveClr = !bus.if_req || (w_issue && w_pickIf);
      w_starveInc = w_issue && !w_pickIf && bus.if_req;
    end
  end

endmodule

// File: tb/tb_philv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_philv_mem_arbiter
// Directed bench for the unified-memory arbiter. Stimulus pushes the expected
// memory commands and responses (with their cycle numbers) into queues; a
// monitor on the falling edge pops and compares whenever the DUT issues a
// command or raises an rvalid. A small memory model with two-cycle read
// latency sits on the memory port.
// -----------------------------------------------------------------------------
module tb_philv_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int SLIM = 4;

  typedef struct {
    bit          isLs;
    logic [31:0] addr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          cyc;
  } gnt_t;

  typedef struct {
    bit          isLs;
    logic [31:0] data;
    int          cyc;
  } resp_t;

  logic        clk = 1'b0;
  logic        rstb;
  logic        busy;
  int          cyc = 0;
  int          tests = 0;
  int          failed = 0;
  int          c0;
  gnt_t        gntQ[$];
  resp_t       respQ[$];
  gnt_t        monGnt;
  resp_t       monResp;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rdPipe;

  philv_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  philv_mem_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .MEM_LATENCY  (LAT),
    .STARVE_LIMIT (SLIM)
  ) dut (
    .i_clk  (clk),
    .i_rstb (rstb),
    .bus    (bus),
    .o_busy (busy)
  );

  // Free-running clock and cycle counter used to timestamp expectations.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memRead(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'hC0DE0000);
  endfunction

  // Memory model: command sampled at the end of the issue cycle, data shows
  // up on mem_rdata two cycles after the issue cycle. Junk fills the pipe
  // otherwise so a store ack that leaks mem_rdata is visible.
  always @(posedge clk) begin
    logic [31:0] w;
    if (bus.mem_en && !bus.mem_we) begin
      rdPipe <= memRead(bus.mem_addr);
    end else begin
      rdPipe <= 32'hA5A5A5A5;
    end
    if (bus.mem_en && bus.mem_we) begin
      w = memRead(bus.mem_addr);
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_be[b]) w[b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
      end
      mem[bus.mem_addr] = w;
    end
    bus.mem_rdata <= rdPipe;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input bit ifReq, input logic [31:0] ifAddr,
                               input bit lsReq, input bit lsWe, input logic [31:0] lsAddr,
                               input logic [31:0] lsWdata, input logic [3:0] lsBe);
    bus.if_req   = ifReq;
    bus.if_addr  = ifAddr;
    bus.ls_req   = lsReq;
    bus.ls_we    = lsWe;
    bus.ls_addr  = lsAddr;
    bus.ls_wdata = lsWdata;
    bus.ls_be    = lsBe;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expectCmd(input bit isLs, input logic [31:0] addr, input bit we,
                           input logic [3:0] be, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int gntCyc, input bit withResp);
    gnt_t  g;
    resp_t r;
    g.isLs = isLs; g.addr = addr; g.we = we; g.be = be; g.wdata = wdata; g.cyc = gntCyc;
    gntQ.push_back(g);
    if (withResp) begin
      r.isLs = isLs; r.data = rdata; r.cyc = gntCyc + LAT;
      respQ.push_back(r);
    end
  endtask

  // Monitor: structural invariants every cycle, then pop-and-compare on each
  // memory command and each rvalid.
  always @(negedge clk) begin
    checkOutput("gntExclusive", 32'(bus.if_gnt & bus.ls_gnt), 32'd0);
    checkOutput("rvalidExclusive", 32'(bus.if_rvalid & bus.ls_rvalid), 32'd0);
    checkOutput("gntWithoutEn", 32'((bus.if_gnt | bus.ls_gnt) & ~bus.mem_en), 32'd0);
    if (bus.mem_en === 1'b1) begin
      checkOutput("issueExpected", 32'(gntQ.size() > 0), 32'd1);
      if (gntQ.size() > 0) begin
        monGnt = gntQ.pop_front();
        checkOutput("gntCycle", 32'(cyc), 32'(monGnt.cyc));
        checkOutput("gntPresent", 32'(bus.if_gnt | bus.ls_gnt), 32'd1);
        checkOutput("gntSource", 32'(bus.ls_gnt), 32'(monGnt.isLs));
        checkOutput("memAddr", bus.mem_addr, monGnt.addr);
        checkOutput("memWe", 32'(bus.mem_we), 32'(monGnt.we));
        checkOutput("memBe", 32'(bus.mem_be), 32'(monGnt.be));
        if (monGnt.we) checkOutput("memWdata", bus.mem_wdata, monGnt.wdata);
      end
    end
    if ((bus.if_rvalid === 1'b1) || (bus.ls_rvalid === 1'b1)) begin
      checkOutput("rvalidExpected", 32'(respQ.size() > 0), 32'd1);
      if (respQ.size() > 0) begin
        monResp = respQ.pop_front();
        checkOutput("rvalidCycle", 32'(cyc), 32'(monResp.cyc));
        checkOutput("rvalidSource", 32'(bus.ls_rvalid), 32'(monResp.isLs));
        checkOutput("rdata", monResp.isLs ? bus.ls_rdata : bus.if_rdata, monResp.data);
      end
    end
  end

  // Hard stop in case the run never reaches its summary.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mem[32'h10]  = 32'h00500113;
    mem[32'h20]  = 32'h00A00193;
    mem[32'h40]  = 32'h00000297;
    mem[32'h100] = 32'h11223344;
    mem[32'h200] = 32'hCAFEF00D;
    mem[32'h204] = 32'h0BADC0DE;
    mem[32'h300] = 32'h12345678;

    // Reset held for three cycles with a fetch pending.
    rstb = 1'b0;
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) begin
      nextCycle();
      @(negedge clk);
      checkOutput("rstIfGnt", 32'(bus.if_gnt), 32'd0);
      checkOutput("rstLsGnt", 32'(bus.ls_gnt), 32'd0);
      checkOutput("rstMemEn", 32'(bus.mem_en), 32'd0);
      checkOutput("rstBusy", 32'(busy), 32'd0);
    end
    nextCycle();
    rstb = 1'b1;
    c0 = cyc;
    expectCmd(1'b0, 32'h10, 1'b0, 4'hF, 32'h0, 32'h00500113, c0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) nextCycle();
    @(negedge clk);
    checkOutput("idleAfterRelease", 32'(busy), 32'd0);

    // Single fetch.
    nextCycle();
    c0 = cyc;
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    expectCmd(1'b0, 32'h10, 1'b0, 4'hF, 32'h0, 32'h00500113, c0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("fetchBusy", 32'(busy), 32'd1);
    repeat (2) nextCycle();
    @(negedge clk);
    checkOutput("fetchIdle", 32'(busy), 32'd0);

    // Simultaneous requests: LS first, IF in the response cycle.
    nextCycle();
    c0 = cyc;
    applyStimulus(1'b1, 32'h20, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    expectCmd(1'b1, 32'h200, 1'b0, 4'hF, 32'h0, 32'hCAFEF00D, c0, 1'b1);
    expectCmd(1'b0, 32'h20, 1'b0, 4'hF, 32'h0, 32'h00A00193, c0 + 2, 1'b1);
    nextCycle();
    bus.ls_req = 1'b0;
    nextCycle();
    nextCycle();
    bus.if_req = 1'b0;
    repeat (2) nextCycle();
    @(negedge clk);
    checkOutput("simulIdle", 32'(busy), 32'd0);

    // Starvation: both held, IF forced in after four LS grants.
    nextCycle();
    c0 = cyc;
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      expectCmd(1'b1, 32'h300, 1'b0, 4'hF, 32'h0, 32'h12345678, c0 + 2 * k, 1'b1);
    end
    expectCmd(1'b0, 32'h40, 1'b0, 4'hF, 32'h0, 32'h00000297, c0 + 8, 1'b1);
    expectCmd(1'b1, 32'h300, 1'b0, 4'hF, 32'h0, 32'h12345678, c0 + 10, 1'b1);
    repeat (11) nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) nextCycle();
    @(negedge clk);
    checkOutput("starveIdle", 32'(busy), 32'd0);

    // Partial store, then read back from the response cycle.
    nextCycle();
    c0 = cyc;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'b0011);
    expectCmd(1'b1, 32'h100, 1'b1, 4'b0011, 32'hDEADBEEF, 32'h0, c0, 1'b1);
    nextCycle();
    bus.ls_req = 1'b0;
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    expectCmd(1'b1, 32'h100, 1'b0, 4'hF, 32'h0, 32'h1122BEEF, c0 + 2, 1'b1);
    nextCycle();
    bus.ls_req = 1'b0;
    repeat (2) nextCycle();

    // Reset while a load is outstanding: response is dropped.
    nextCycle();
    c0 = cyc;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    expectCmd(1'b1, 32'h200, 1'b0, 4'hF, 32'h0, 32'h0, c0, 1'b0);
    nextCycle();
    bus.ls_req = 1'b0;
    rstb = 1'b0;
    @(negedge clk);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    nextCycle();
    rstb = 1'b1;
    @(negedge clk);
    checkOutput("postRstBusy", 32'(busy), 32'd0);
    checkOutput("postRstLsRvalid", 32'(bus.ls_rvalid), 32'd0);
    nextCycle();
    c0 = cyc;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h204, 32'h0, 4'h0);
    expectCmd(1'b1, 32'h204, 1'b0, 4'hF, 32'h0, 32'h0BADC0DE, c0, 1'b1);
    nextCycle();
    bus.ls_req = 1'b0;
    repeat (2) nextCycle();
    @(negedge clk);
    checkOutput("finalIdle", 32'(busy), 32'd0);

    repeat (2) nextCycle();
    checkOutput("gntQueueDrained", 32'(gntQ.size()), 32'd0);
    checkOutput("respQueueDrained", 32'(respQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
